// File: rtl/hyperbus_pkg.sv
// Shared state encoding, word-width helper and watchdog default for the HyperBus burst master.
// The watchdog itself is enabled in the top by defining HBUS_TIMEOUT_EN.
package hyperbus_pkg;

    localparam logic [5:0] OH_IDLE  = 6'b000001;
    localparam logic [5:0] OH_FILL  = 6'b000010;
    localparam logic [5:0] OH_REQ   = 6'b000100;
    localparam logic [5:0] OH_XFER  = 6'b001000;
    localparam logic [5:0] OH_DRAIN = 6'b010000;
    localparam logic [5:0] OH_ERROR = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE  = OH_IDLE,
        ST_FILL  = OH_FILL,
        ST_REQ   = OH_REQ,
        ST_XFER  = OH_XFER,
        ST_DRAIN = OH_DRAIN,
        ST_ERROR = OH_ERROR
    } hb_state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic int word_width(input int dq_width);
        return 32'sd2 * dq_width;
    endfunction

endpackage

// File: rtl/hyperbus_wbuf.sv
// Write-word buffer: synchronous FIFO with first-word-fall-through output.
// full_nxt predicts fullness after the current edge so the caller can register its ready.
module hyperbus_wbuf
    import hyperbus_pkg::*;
#(
    parameter int DW   = 16,
    parameter int LOG2 = 4
) (
    input  logic            clk90,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic [LOG2:0]   count,
    output logic            full,
    output logic            empty,
    output logic            full_nxt
);

    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2:0]   CNT_DEPTH = (LOG2 + 1)'(DEPTH);
    localparam logic [LOG2:0]   CNT_ONE   = (LOG2 + 1)'(1);
    localparam logic [LOG2:0]   CNT_ZERO  = {(LOG2 + 1){1'b0}};
    localparam logic [LOG2-1:0] PTR_ONE   = LOG2'(1);
    localparam logic [LOG2-1:0] PTR_ZERO  = {LOG2{1'b0}};

    logic [DW-1:0]   mem [DEPTH];
    logic [LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]   count_q, count_d;
    logic            do_push_s, do_pop_s;

    // Pointer and occupancy update; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        do_push_s = push && (count_q != CNT_DEPTH);
        do_pop_s  = pop && (count_q != CNT_ZERO);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer/count registers; reset discards any buffered words.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk90) begin
        if (do_push_s) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout     = mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_DEPTH);
    assign empty    = (count_q == CNT_ZERO);
    assign full_nxt = (count_d == CNT_DEPTH);

endmodule

// File: rtl/hyperbus_burst_master.sv
// Burst sequencer in front of the HyperBus primary controller: one command, exactly cmd_len words.
// Define HBUS_TIMEOUT_EN to add an idle-beat watchdog on the XFER state.
module hyperbus_burst_master
    import hyperbus_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int WBUF_LOG2   = 4
`ifdef HBUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
`endif
) (
    input  logic                          clk90,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic                          cmd_reg,
    input  logic [ADDR_LENGTH-1:0]        cmd_adr,
    input  logic [LEN_WIDTH-1:0]          cmd_len,
    input  logic [word_width(WIDTH)-1:0]  wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [word_width(WIDTH)-1:0]  rd_data,
    output logic                          rd_valid,
    output logic                          done,
    output logic                          done_err,
    output logic [ADDR_LENGTH-1:0]        hb_adr,
    output logic                          hb_reg,
    output logic [word_width(WIDTH)-1:0]  hb_wdat,
    output logic                          hb_wrq,
    output logic                          hb_rrq,
    input  logic                          hb_ready,
    input  logic                          hb_valid,
    input  logic                          hb_busy,
    input  logic                          hb_error,
    input  logic [word_width(WIDTH)-1:0]  hb_rdat
);

    localparam int DW         = word_width(WIDTH);
    localparam int WBUF_DEPTH = 1 << WBUF_LOG2;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

    hb_state_t               state_q, state_d;
    logic [ADDR_LENGTH-1:0]  hb_adr_q, hb_adr_d;
    logic                    hb_reg_q, hb_reg_d;
    logic                    we_q, we_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]           hb_wdat_q, hb_wdat_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    done_q, done_d;
    logic                    done_err_q, done_err_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    hb_wrq_q, hb_wrq_d;
    logic                    hb_rrq_q, hb_rrq_d;
    logic                    abort_q, abort_d;
`ifdef HBUS_TIMEOUT_EN
    logic [15:0]             wd_q, wd_d;
`endif

    logic                    hb_ready_q, hb_valid_q, hb_busy_q, hb_error_q;
    logic [DW-1:0]           hb_rdat_q;

    logic                    buf_push_s, buf_pop_s, buf_full_s, buf_empty_s, buf_full_nxt_s;
    logic [DW-1:0]           buf_dout_s;
    logic [WBUF_LOG2:0]      buf_count_s;
    logic                    beat_s;

    hyperbus_wbuf #(
        .DW   (DW),
        .LOG2 (WBUF_LOG2)
    ) u_wbuf (
        .clk90    (clk90),
        .rst      (rst),
        .push     (buf_push_s),
        .pop      (buf_pop_s),
        .din      (wr_data),
        .dout     (buf_dout_s),
        .count    (buf_count_s),
        .full     (buf_full_s),
        .empty    (buf_empty_s),
        .full_nxt (buf_full_nxt_s)
    );

    assign buf_push_s = wr_valid && wr_ready_q && !buf_full_s;

    // A beat is one word moved: a buffered word popped on hb_ready, or a read word on hb_valid.
    assign beat_s = ((state_q == ST_REQ) || (state_q == ST_XFER)) && (cnt_q != LEN_ZERO) &&
                    (we_q ? (hb_ready_q && !buf_empty_s) : hb_valid_q);

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        hb_adr_d   = hb_adr_q;
        hb_reg_d   = hb_reg_q;
        we_d       = we_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        hb_wdat_d  = hb_wdat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        abort_d    = abort_q;
        buf_pop_s  = 1'b0;
`ifdef HBUS_TIMEOUT_EN
        wd_d       = 16'd0;
`endif
        if (hb_error_q) begin
            state_d = ST_ERROR;
            if (state_q != ST_ERROR) begin
                done_d     = 1'b1;
                done_err_d = 1'b1;
            end else begin
                done_d     = 1'b0;
                done_err_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    abort_d = 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        hb_adr_d = cmd_adr;
                        hb_reg_d = cmd_reg;
                        we_d     = cmd_we;
                        len_d    = cmd_len;
                        cnt_d    = cmd_len;
                        if (cmd_len == LEN_ZERO) begin
                            done_d = 1'b1;
                        end else if (cmd_we && (32'(cmd_len) > WBUF_DEPTH)) begin
                            // Burst can never fit in the buffer: reject without touching the bus.
                            done_d     = 1'b1;
                            done_err_d = 1'b1;
                        end else if (cmd_we) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (32'(buf_count_s) >= 32'(len_q)) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_REQ, ST_XFER: begin
                    if (beat_s) begin
                        cnt_d = cnt_q - LEN_ONE;
                        if (we_q) begin
                            buf_pop_s = 1'b1;
                            hb_wdat_d = buf_dout_s;
                        end else begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = hb_rdat_q;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (cnt_d == LEN_ZERO) begin
                        state_d = ST_DRAIN;
                    end else if ((state_q == ST_REQ) && hb_busy_q) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = state_q;
                    end
`ifdef HBUS_TIMEOUT_EN
                    if ((state_q == ST_XFER) && !beat_s) begin
                        if (32'(wd_q) >= (TIMEOUT - 32'sd1)) begin
                            abort_d = 1'b1;
                            state_d = ST_DRAIN;
                            wd_d    = 16'd0;
                        end else begin
                            wd_d = wd_q + 16'd1;
                        end
                    end else begin
                        wd_d = 16'd0;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (!hb_busy_q) begin
                        done_d     = 1'b1;
                        done_err_d = abort_q;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
        // Outputs are derived from the next state so they line up with it after the edge.
        cmd_ready_d = (state_d == ST_IDLE);
        hb_wrq_d    = we_d && ((state_d == ST_REQ) || (state_d == ST_XFER));
        hb_rrq_d    = !we_d && ((state_d == ST_REQ) || (state_d == ST_XFER));
        wr_ready_d  = !buf_full_nxt_s;
    end

    // Controller status and read data are registered once on entry.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            hb_ready_q <= 1'b0;
            hb_valid_q <= 1'b0;
            hb_busy_q  <= 1'b0;
            hb_error_q <= 1'b0;
            hb_rdat_q  <= {DW{1'b0}};
        end else begin
            hb_ready_q <= hb_ready;
            hb_valid_q <= hb_valid;
            hb_busy_q  <= hb_busy;
            hb_error_q <= hb_error;
            hb_rdat_q  <= hb_rdat;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hb_adr_q    <= {ADDR_LENGTH{1'b0}};
            hb_reg_q    <= 1'b0;
            we_q        <= 1'b0;
            len_q       <= LEN_ZERO;
            cnt_q       <= LEN_ZERO;
            hb_wdat_q   <= {DW{1'b0}};
            rd_data_q   <= {DW{1'b0}};
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            hb_wrq_q    <= 1'b0;
            hb_rrq_q    <= 1'b0;
            abort_q     <= 1'b0;
`ifdef HBUS_TIMEOUT_EN
            wd_q        <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            hb_adr_q    <= hb_adr_d;
            hb_reg_q    <= hb_reg_d;
            we_q        <= we_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hb_wdat_q   <= hb_wdat_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            hb_wrq_q    <= hb_wrq_d;
            hb_rrq_q    <= hb_rrq_d;
            abort_q     <= abort_d;
`ifdef HBUS_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign hb_adr    = hb_adr_q;
    assign hb_reg    = hb_reg_q;
    assign hb_wdat   = hb_wdat_q;
    assign hb_wrq    = hb_wrq_q;
    assign hb_rrq    = hb_rrq_q;

endmodule

// File: tb/tb_hyperbus_burst_master.sv
// Scoreboard bench for hyperbus_burst_master: a simple controller model answers requests,
// expected words/done/address are queued at stimulus time and popped by a monitor.
module tb_hyperbus_burst_master;

    logic        clk90 = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we, cmd_reg;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, done, done_err;
    logic [31:0] hb_adr;
    logic        hb_reg;
    logic [15:0] hb_wdat;
    logic        hb_wrq, hb_rrq;
    logic        hb_ready, hb_valid, hb_busy, hb_error;
    logic [15:0] hb_rdat;

    always #5 clk90 = ~clk90;

    hyperbus_burst_master dut (
        .clk90(clk90), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_reg(cmd_reg),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .done_err(done_err),
        .hb_adr(hb_adr), .hb_reg(hb_reg), .hb_wdat(hb_wdat), .hb_wrq(hb_wrq), .hb_rrq(hb_rrq),
        .hb_ready(hb_ready), .hb_valid(hb_valid), .hb_busy(hb_busy), .hb_error(hb_error),
        .hb_rdat(hb_rdat)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_wd_q[$];
    logic        exp_done_q[$];
    logic [33:0] exp_adr_q[$];

    int          model_beats = 0;
    int          err_beat = -1;
    int          seq = 0;
    logic [15:0] rdat_tbl [0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: raise busy on a request, then serve model_beats beats or an error.
    initial begin
        hb_busy = 1'b0; hb_ready = 1'b0; hb_valid = 1'b0; hb_error = 1'b0; hb_rdat = 16'h0000;
        forever begin
            @(posedge clk90); #2;
            hb_ready = 1'b0; hb_valid = 1'b0; hb_error = 1'b0;
            if (rst) begin
                hb_busy = 1'b0;
            end else if (hb_wrq || hb_rrq) begin
                if (!hb_busy) begin
                    hb_busy = 1'b1;
                    seq = 0;
                end else if (seq == err_beat) begin
                    hb_error = 1'b1;
                    err_beat = -1;
                end else if (seq < model_beats) begin
                    if (hb_wrq) begin
                        hb_ready = 1'b1;
                    end else begin
                        hb_valid = 1'b1;
                        hb_rdat  = rdat_tbl[seq];
                    end
                    seq++;
                end
            end else begin
                hb_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    initial begin
        logic        prev_req;
        logic [15:0] last_wdat;
        prev_req  = 1'b0;
        last_wdat = 16'h0000;
        forever begin
            @(negedge clk90);
            if (rst) begin
                prev_req  = 1'b0;
                last_wdat = hb_wdat;
            end else begin
                if (rd_valid) begin
                    if (exp_rd_q.size() == 0) begin
                        n_total++;
                        $display("FAIL rd_unexpected: rd_valid with data 0x%0h, expected no strobe", rd_data);
                    end else begin
                        check("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
                    end
                end
                if (hb_wdat != last_wdat) begin
                    if (exp_wd_q.size() == 0) begin
                        n_total++;
                        $display("FAIL wdat_unexpected: hb_wdat 0x%0h, expected no new word", hb_wdat);
                    end else begin
                        check("hb_wdat", 64'(hb_wdat), 64'(exp_wd_q.pop_front()));
                    end
                    last_wdat = hb_wdat;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        n_total++;
                        $display("FAIL done_unexpected: done=1 err=%0b, expected no done", done_err);
                    end else begin
                        check("done_err", 64'(done_err), 64'(exp_done_q.pop_front()));
                    end
                end
                if ((hb_wrq || hb_rrq) && !prev_req) begin
                    if (exp_adr_q.size() == 0) begin
                        n_total++;
                        $display("FAIL req_unexpected: wrq=%0b rrq=%0b, expected no request", hb_wrq, hb_rrq);
                    end else begin
                        check("req_we_reg_adr", 64'({hb_wrq, hb_reg, hb_adr}), 64'(exp_adr_q.pop_front()));
                    end
                end
                prev_req = hb_wrq || hb_rrq;
            end
        end
    end

    task automatic send_cmd(input logic we, input logic rg, input logic [31:0] adr, input logic [7:0] len);
        int  t;
        bit  acc;
        t = 0;
        acc = 1'b0;
        @(posedge clk90); #1;
        cmd_we = we; cmd_reg = rg; cmd_adr = adr; cmd_len = len; cmd_valid = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clk90);
            acc = cmd_ready;
            @(posedge clk90); #1;
            t++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            check("cmd_accept", 64'(acc), 64'(1));
        end
    endtask

    task automatic push_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            bit acc;
            t = 0;
            acc = 1'b0;
            @(posedge clk90); #1;
            wr_data  = base + 16'(i);
            wr_valid = 1'b1;
            while (!acc && t < 100) begin
                @(negedge clk90);
                acc = wr_ready;
                @(posedge clk90); #1;
                t++;
            end
            wr_valid = 1'b0;
            if (!acc) begin
                check("wr_accept", 64'(acc), 64'(1));
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_rd_q.size() + exp_wd_q.size() + exp_done_q.size() + exp_adr_q.size()) != 0 &&
               n < budget) begin
            @(posedge clk90);
            n++;
        end
        check(name, 64'(exp_rd_q.size() + exp_wd_q.size() + exp_done_q.size() + exp_adr_q.size()), 64'(0));
        exp_rd_q.delete(); exp_wd_q.delete(); exp_done_q.delete(); exp_adr_q.delete();
    endtask

    initial begin
        int hi_cnt;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_reg = 1'b0; cmd_adr = 32'h0; cmd_len = 8'h0;
        wr_data = 16'h0; wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) rdat_tbl[i] = 16'h0000;

        // Reset state.
        repeat (3) @(posedge clk90);
        @(negedge clk90);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_wr_ready",  64'(wr_ready),  64'(0));
        check("rst_done",      64'(done),      64'(0));
        check("rst_reqs",      64'({hb_wrq, hb_rrq}), 64'(0));
        check("rst_rd_valid",  64'(rd_valid),  64'(0));
        rst = 1'b0;
        #1 check("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
        @(negedge clk90);
        check("cmd_ready_after_edge", 64'(cmd_ready), 64'(1));
        check("wr_ready_after_edge",  64'(wr_ready),  64'(1));

        // Write burst of four words.
        model_beats = 4;
        exp_adr_q.push_back({1'b1, 1'b0, 32'h0000_0100});
        for (int i = 0; i < 4; i++) exp_wd_q.push_back(16'hA001 + 16'(i));
        exp_done_q.push_back(1'b0);
        send_cmd(1'b1, 1'b0, 32'h0000_0100, 8'd4);
        push_words(16'hA001, 4);
        wait_drain("write_drain", 300);
        repeat (5) @(posedge clk90);

        // Read burst of three; the model offers a fourth word that must be dropped.
        rdat_tbl[0] = 16'h1111; rdat_tbl[1] = 16'h2222; rdat_tbl[2] = 16'h3333; rdat_tbl[3] = 16'h4444;
        exp_adr_q.push_back({1'b0, 1'b0, 32'h0000_0200});
        exp_rd_q.push_back(16'h1111); exp_rd_q.push_back(16'h2222); exp_rd_q.push_back(16'h3333);
        exp_done_q.push_back(1'b0);
        send_cmd(1'b0, 1'b0, 32'h0000_0200, 8'd3);
        wait_drain("read_drain", 300);
        repeat (8) @(posedge clk90);

        // Zero-length command: done next cycle, no request.
        exp_done_q.push_back(1'b0);
        send_cmd(1'b0, 1'b0, 32'h0000_0300, 8'd0);
        @(negedge clk90);
        check("len0_done_next_cycle", 64'(done), 64'(1));
        wait_drain("len0_drain", 20);
        repeat (5) @(posedge clk90);

        // Oversized write is rejected; the next (register-space) read is still accepted.
        exp_done_q.push_back(1'b1);
        send_cmd(1'b1, 1'b0, 32'h0000_0400, 8'd20);
        @(negedge clk90);
        check("reject_done_err", 64'(done_err), 64'(1));
        wait_drain("reject_drain", 20);
        repeat (3) @(posedge clk90);
        model_beats = 1;
        rdat_tbl[0] = 16'h5555;
        exp_adr_q.push_back({1'b0, 1'b1, 32'h0000_0500});
        exp_rd_q.push_back(16'h5555);
        exp_done_q.push_back(1'b0);
        send_cmd(1'b0, 1'b1, 32'h0000_0500, 8'd1);
        wait_drain("after_reject_drain", 300);
        repeat (5) @(posedge clk90);

        // Reset in the middle of a stalled read drops the request immediately.
        model_beats = 1;
        rdat_tbl[0] = 16'h7777;
        exp_adr_q.push_back({1'b0, 1'b0, 32'h0000_0800});
        exp_rd_q.push_back(16'h7777);
        send_cmd(1'b0, 1'b0, 32'h0000_0800, 8'd3);
        wait_drain("midrst_first_beat", 100);
        repeat (3) @(posedge clk90);
        #1 rst = 1'b1;
        #1 check("midrst_rrq_drop", 64'(hb_rrq), 64'(0));
        repeat (2) @(posedge clk90);
        @(negedge clk90) rst = 1'b0;
        repeat (3) @(posedge clk90);

        // Controller error during a write: one failed done, then stuck until reset.
        model_beats = 4;
        err_beat = 2;
        exp_adr_q.push_back({1'b1, 1'b0, 32'h0000_0600});
        exp_wd_q.push_back(16'hB001); exp_wd_q.push_back(16'hB002);
        exp_done_q.push_back(1'b1);
        send_cmd(1'b1, 1'b0, 32'h0000_0600, 8'd4);
        push_words(16'hB001, 4);
        wait_drain("error_drain", 300);
        hi_cnt = 0;
        @(posedge clk90); #1 cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk90);
            if (cmd_ready || hb_wrq || hb_rrq) hi_cnt++;
        end
        cmd_valid = 1'b0;
        check("error_stuck_no_ready", 64'(hi_cnt), 64'(0));
        err_beat = -1;
        @(negedge clk90) rst = 1'b1;
        @(negedge clk90) rst = 1'b0;
        @(negedge clk90);
        check("error_cleared_by_rst", 64'(cmd_ready), 64'(1));

`ifdef HBUS_TIMEOUT_EN
        // Watchdog: read of two, model stalls after one beat.
        model_beats = 1;
        rdat_tbl[0] = 16'h6666;
        exp_adr_q.push_back({1'b0, 1'b0, 32'h0000_0700});
        exp_rd_q.push_back(16'h6666);
        exp_done_q.push_back(1'b1);
        send_cmd(1'b0, 1'b0, 32'h0000_0700, 8'd2);
        wait_drain("timeout_drain", 1000);
        @(negedge clk90);
        check("timeout_back_idle", 64'(cmd_ready), 64'(1));
`endif

        repeat (5) @(posedge clk90);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
